// File: rtl/move_drain_if.sv
// Move-drain bus bundle: FIFO read side plus the outgoing move stream.
//   fifoOut   : FIFO read data (valid the cycle after rden)
//   fifoEmpty : FIFO empty flag
//   rden      : FIFO read request pulse
//   mv_data   : current move (invalid bit always 0)
//   mv_valid  : mv_data valid
//   mv_ready  : downstream accepts mv_data this cycle
// master = drain block, slave = FIFO/collector side.
interface move_drain_if #(
  parameter int WORD_W = 160,
  parameter int MOVE_W = 19
);
  logic [WORD_W-1:0] fifoOut;
  logic              fifoEmpty;
  logic              rden;
  logic [MOVE_W-1:0] mv_data;
  logic              mv_valid;
  logic              mv_ready;

  modport master (
    input  fifoOut, fifoEmpty, mv_ready,
    output rden, mv_data, mv_valid
  );

  modport slave (
    output fifoOut, fifoEmpty, mv_ready,
    input  rden, mv_data, mv_valid
  );
endinterface

// File: rtl/move_drain.sv
// move_drain: pops 160-bit move words from a square unit's FIFO, drops
// slots flagged invalid and streams survivors one per handshake, highest
// slot first. Raises done once the producer is finished and both the FIFO
// and the local word are drained.
//   clk, reset : clock, synchronous active-low reset
//   start      : begin a drain (honoured in IDLE or FIN only)
//   src_done   : producer will write no more words
//   mv_count   : moves accepted since start, saturating
//   done       : drain complete, held until next start/reset
//   bus        : FIFO read port and move stream (move_drain_if.master)
module move_drain #(
  parameter int SLOTS  = 8,
  parameter int MOVE_W = 19,
  parameter int WORD_W = 160,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             src_done,
  output logic [CNT_W-1:0] mv_count,
  output logic             done,
  move_drain_if.master     bus
);

  typedef enum logic [2:0] {IDLE, FILL, LOAD, UNPK, FIN} state_t;

  state_t state, state_nxt;

  logic [SLOTS-1:0][MOVE_W-1:0] word_q;
  logic [SLOTS-1:0][MOVE_W-1:0] in_slots;
  logic [SLOTS-1:0]             mask_q, mask_nxt, in_mask, top_oh;
  logic [MOVE_W-1:0]            top_slot;
  logic                         accept;

  assign in_slots = bus.fifoOut[SLOTS*MOVE_W-1:0];

  // A slot survives when its invalid flag (slot MSB) is clear.
  for (genvar k = 0; k < SLOTS; k++) begin : g_mask
    assign in_mask[k] = ~in_slots[k][MOVE_W-1];
  end

  // Highest surviving slot: ascending scan, last hit wins. Registers only,
  // so mv_data has no combinational path from the inputs.
  always_comb begin
    top_oh   = '0;
    top_slot = '0;
    for (int k = 0; k < SLOTS; k++) begin
      if (mask_q[k]) begin
        top_oh    = '0;
        top_oh[k] = 1'b1;
        top_slot  = word_q[k];
      end
    end
  end

  assign accept   = bus.mv_valid && bus.mv_ready;
  assign mask_nxt = accept ? (mask_q & ~top_oh) : mask_q;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic. Emptiness is tested before src_done so a word written
  // just before the producer finished is still collected.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = FILL;
      FILL: begin
        if (!bus.fifoEmpty) state_nxt = LOAD;
        else if (src_done)  state_nxt = FIN;
      end
      LOAD: state_nxt = UNPK;
      UNPK: if (mask_nxt == '0) state_nxt = FILL;
      FIN:  if (start) state_nxt = FILL;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs. rden lives only in FILL, which always exits to LOAD after a
  // read, so it can never fire on back-to-back cycles.
  always_comb begin
    bus.rden     = 1'b0;
    bus.mv_valid = 1'b0;
    bus.mv_data  = '0;
    done         = 1'b0;
    case (state)
      FILL: bus.rden = !bus.fifoEmpty;
      UNPK: begin
        bus.mv_valid = |mask_q;
        if (|mask_q) bus.mv_data = {1'b0, top_slot[MOVE_W-2:0]};
      end
      FIN:  done = 1'b1;
      default: ;
    endcase
  end

  // Word/mask datapath and emitted-move counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      word_q   <= '0;
      mask_q   <= '0;
      mv_count <= '0;
    end else begin
      if (state == LOAD) begin
        word_q <= in_slots;
        mask_q <= in_mask;
      end else if (state == UNPK) begin
        mask_q <= mask_nxt;
      end

      if ((state == IDLE || state == FIN) && start)
        mv_count <= '0;
      else if (accept && mv_count != {CNT_W{1'b1}})
        mv_count <= mv_count + 1'b1;
    end
  end

  // Padding bits and the (always clear) invalid bit of the selected slot
  // carry no information.
  logic unused_bits;
  assign unused_bits = ^{bus.fifoOut[WORD_W-1:SLOTS*MOVE_W], top_slot[MOVE_W-1]};

endmodule

// File: tb/tb_move_drain.sv
module tb_move_drain;
  localparam int SLOTS  = 8;
  localparam int MOVE_W = 19;
  localparam int WORD_W = 160;

  localparam int K_SPARSE = 0, K_FULL = 1, K_INV_FULL = 2, K_PAD = 3, K_ALLINV = 4;

  typedef struct {
    int nwords;
    int kind;
    int rnd;        // 1: random mv_ready
    int exp_count;  // expected mv_count at done
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       src_done = 1'b0;
  logic [7:0] mv_count;
  logic       done;

  move_drain_if bus();

  move_drain dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .src_done (src_done),
    .mv_count (mv_count),
    .done     (done),
    .bus      (bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- FIFO model (non-showahead) ----------------
  logic [WORD_W-1:0] mem [64];
  int   wr_ptr = 0;
  int   rd_ptr = 0;
  logic rd_req = 1'b0;

  assign bus.fifoEmpty = (wr_ptr == rd_ptr);
  initial bus.fifoOut = '0;

  always @(posedge clk) begin
    if (rd_req) begin
      bus.fifoOut <= mem[rd_ptr % 64];
      rd_ptr      <= rd_ptr + 1;
    end
  end

  // ---------------- ready generation ----------------
  logic ready_man = 1'b0;
  logic rnd_ready = 1'b0;
  logic rnd_bit = 1'b0;
  assign bus.mv_ready = rnd_ready ? rnd_bit : ready_man;

  always @(posedge clk) begin
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  // ---------------- reference model / scoreboard ----------------
  logic [MOVE_W-1:0] exp_q [$];
  int accepted = 0;
  int reads = 0;

  logic              prev_rden = 1'b0;
  logic              prev_stall = 1'b0;
  logic [MOVE_W-1:0] prev_data = '0;

  // Sampled mid-cycle: what is seen here is what the next rising edge acts on.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.rden) begin
        reads++;
        chk("rden_legal", {bus.fifoEmpty, prev_rden}, 2'b00);
      end
      if (bus.mv_valid && bus.mv_ready) begin
        accepted++;
        if (exp_q.size() == 0) chk("extra_move", bus.mv_data, '1);
        else chk("move_data", bus.mv_data, exp_q.pop_front());
      end
      if (prev_stall)
        chk("stall_hold", {bus.mv_valid, bus.mv_data}, {1'b1, prev_data});
    end
    rd_req     <= bus.rden && reset;
    prev_rden  <= bus.rden && reset;
    prev_stall <= reset && bus.mv_valid && !bus.mv_ready;
    prev_data  <= bus.mv_data;
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: a word contributes its valid slots, slot 7 first, invalid bit clear.
  task automatic push_word(input logic [WORD_W-1:0] w);
    mem[wr_ptr % 64] = w;
    wr_ptr++;
    for (int k = SLOTS - 1; k >= 0; k--)
      if (!w[k*MOVE_W + MOVE_W - 1])
        exp_q.push_back({1'b0, w[k*MOVE_W +: MOVE_W-1]});
  endtask

  function automatic logic [WORD_W-1:0] make_word(input logic [7:0] valid, input bit pad);
    logic [WORD_W-1:0] w;
    w = '0;
    for (int k = 0; k < SLOTS; k++)
      w[k*MOVE_W +: MOVE_W] = {~valid[k], 18'($urandom)};
    if (pad) w[WORD_W-1:SLOTS*MOVE_W] = 8'($urandom) | 8'h01;
    return w;
  endfunction

  logic [MOVE_W-1:0] s7 = {7'b0000001, 6'o12, 6'o23};
  logic [MOVE_W-1:0] s2 = {7'b0010000, 6'o11, 6'o12};

  function automatic logic [WORD_W-1:0] sparse_word();
    logic [WORD_W-1:0] w;
    w = make_word(8'h00, 1'b0);
    w[7*MOVE_W +: MOVE_W] = s7;
    w[2*MOVE_W +: MOVE_W] = s2;
    return w;
  endfunction

  task automatic pulse_start();
    accepted = 0;
    reads = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !done; i++) tick();
    chk("done_reached", done, 1);
    chk("fifo_empty_at_done", bus.fifoEmpty, 1);
    chk("model_drained", exp_q.size(), 0);
  endtask

  task automatic flush();
    wr_ptr = rd_ptr;
    exp_q.delete();
  endtask

  vec_t vecs [7];
  int   nw, tot, exp_sat;
  logic [7:0] m;

  initial begin
    vecs[0] = '{1,  K_SPARSE,   0, 2};
    vecs[1] = '{3,  K_FULL,     0, 24};
    vecs[2] = '{2,  K_INV_FULL, 0, 8};
    vecs[3] = '{1,  K_PAD,      1, 8};
    vecs[4] = '{33, K_FULL,     1, 255};
    vecs[5] = '{1,  K_ALLINV,   0, 0};
    vecs[6] = '{4,  K_FULL,     1, 32};

    // Power-on reset
    tick(); tick();
    reset = 1'b1;
    chk("rst_outputs", {bus.rden, bus.mv_valid, done, mv_count, bus.mv_data}, '0);
    push_word(make_word(8'hFF, 1'b0));
    for (int i = 0; i < 5; i++) tick();
    chk("rst_no_rden_without_start", reads, 0);
    flush();

    // Sparse word: latency, order, consecutive emission
    ready_man = 1'b1;
    src_done = 1'b1;
    push_word(sparse_word());
    pulse_start();
    tick();
    chk("lat_not_yet", bus.mv_valid, 0);
    tick();
    chk("lat_first", {bus.mv_valid, bus.mv_data}, {1'b1, s7});
    tick();
    chk("sparse_second", {bus.mv_valid, bus.mv_data}, {1'b1, s2});
    wait_done(50);
    chk("sparse_count", mv_count, 2);

    // Backpressure
    ready_man = 1'b0;
    push_word(sparse_word());
    pulse_start();
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", {bus.mv_valid, bus.mv_data}, {1'b1, s7});
      tick();
    end
    chk("bp_reads", reads, 1);
    ready_man = 1'b1;
    wait_done(50);
    chk("bp_count", mv_count, 2);
    chk("bp_reads_end", reads, 1);

    // Late producer
    src_done = 1'b0;
    pulse_start();
    for (int i = 0; i < 10; i++) tick();
    chk("late_no_rden", reads, 0);
    chk("late_not_done", done, 0);
    push_word(make_word(8'hFF, 1'b0));
    for (int i = 0; i < 50 && accepted < 8; i++) tick();
    tick();
    chk("late_still_waiting", done, 0);
    src_done = 1'b1;
    wait_done(50);
    chk("late_count", mv_count, 8);

    // Table-driven drains
    foreach (vecs[i]) begin
      rnd_ready = vecs[i].rnd != 0;
      for (int w = 0; w < vecs[i].nwords; w++) begin
        case (vecs[i].kind)
          K_SPARSE:   push_word(sparse_word());
          K_FULL:     push_word(make_word(8'hFF, 1'b0));
          K_INV_FULL: push_word(make_word((w % 2) ? 8'hFF : 8'h00, 1'b0));
          K_PAD:      push_word(make_word(8'hFF, 1'b1));
          default:    push_word(make_word(8'h00, 1'b0));
        endcase
      end
      pulse_start();
      wait_done(3000);
      chk($sformatf("vec%0d_count", i), mv_count, vecs[i].exp_count);
      chk($sformatf("vec%0d_reads", i), reads, vecs[i].nwords);
      if (vecs[i].kind == K_INV_FULL) begin
        // Restart from FIN clears done and the counter on the next cycle
        pulse_start();
        chk("restart_clear", {done, mv_count}, 9'd0);
        wait_done(50);
      end
    end
    rnd_ready = 1'b0;

    // Reset in the middle of unpacking; the popped word is lost
    src_done = 1'b0;
    ready_man = 1'b1;
    push_word(make_word(8'hFF, 1'b0));
    pulse_start();
    tick(); tick(); tick();
    ready_man = 1'b0;
    chk("mid_valid_before_rst", bus.mv_valid, 1);
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    chk("mid_rst_outputs", {bus.rden, bus.mv_valid, done, mv_count, bus.mv_data}, '0);
    exp_q.delete();
    reads = 0;
    push_word(make_word(8'hFF, 1'b0));
    for (int i = 0; i < 5; i++) tick();
    chk("mid_rst_needs_start", reads, 0);
    flush();

    // Randomized drains with a producer that trickles words in
    rnd_ready = 1'b1;
    for (int it = 0; it < 20; it++) begin
      src_done = 1'b0;
      nw = $urandom_range(1, 4);
      tot = 0;
      pulse_start();
      for (int w = 0; w < nw; w++) begin
        for (int g = $urandom_range(0, 5); g > 0; g--) tick();
        m = 8'($urandom);
        tot += $countones(m);
        push_word(make_word(m, 1'($urandom)));
      end
      for (int g = $urandom_range(0, 8); g > 0; g--) tick();
      src_done = 1'b1;
      wait_done(500);
      exp_sat = (accepted > 255) ? 255 : accepted;
      chk("rnd_moves", accepted, tot);
      chk("rnd_count", mv_count, exp_sat);
      chk("rnd_reads", reads, nw);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/move_drain.md
Name: move_drain

Overview:
- Reader for one square unit's move FIFO.
- Pops 160-bit FIFO words, unpacks the eight 19-bit move slots, discards slots whose invalid flag is set, and presents the surviving moves one per handshake on a valid/ready stream toward the move-list collector.
- Signals done once the square has finished generating and its FIFO and local buffer are both drained.

Parameters:
- SLOTS, 8, move slots per FIFO word.
- MOVE_W, 19, bits per move: [invalid][promote][pawn move][pawn 2 sq][en passant][castle][capture][6b from][6b to].
- WORD_W, 160, FIFO word width; bits [159:SLOTS*MOVE_W] are padding and are ignored.
- CNT_W, 8, width of the emitted-move counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  single-cycle pulse that begins a drain; honoured only in IDLE or FIN.
- src_done  in  1  square unit's done flag; high means no further FIFO writes will occur.
- fifoOut  in  160  FIFO read data; valid the cycle after rden is asserted (non-showahead).
- fifoEmpty  in  1  FIFO empty flag.
- rden  out  1  FIFO read request; single-cycle pulse.
- mv_data  out  19  current move, in the slot format above; the invalid bit is always 0.
- mv_valid  out  1  mv_data is valid.
- mv_ready  in  1  downstream accepts mv_data this cycle.
- mv_count  out  8  moves accepted since start; saturates at 255.
- done  out  1  drain complete; held high until the next start or reset.

Behaviour:
- Slot mapping: slot k occupies bits [19k+18:19k]; bit 19k+18 is the invalid flag. Slots are emitted highest first (slot 7 down to slot 0).
- Reset (reset==0 at clk edge) sets:
  - state=IDLE, rden=0, mv_valid=0, mv_data=0, done=0, mv_count=0;
  - word register=0, slot mask=0.
  - Reset is legal mid-operation. FIFO contents are not flushed; a word already popped but not yet emitted is lost.
- IDLE: all outputs inactive. On start, go to FILL and clear mv_count.
- FILL:
  - If fifoEmpty==0: assert rden for exactly this cycle, go to LOAD.
  - Else if src_done==1: go to FIN.
  - Otherwise remain in FILL.
  - Emptiness is checked before src_done, so words written before done are never missed.
- LOAD: capture fifoOut into the word register; mask[k] = ~fifoOut[19k+18]; go to UNPK.
- UNPK:
  - mv_valid = (mask != 0). mv_data = word slot at the highest set mask bit, muxed from registers only (no path from inputs).
  - When mv_valid && mv_ready: clear that mask bit and increment mv_count (saturating at 255).
  - When the mask becomes 0, whether after the last acceptance or on entry with an all-invalid word, go to FILL. An all-invalid word emits nothing and costs one cycle.
  - While mv_valid && !mv_ready, mv_data and mv_valid hold stable.
- FIN: done=1. A start here clears done and mv_count and enters FILL next cycle. Other inputs are ignored.
- start in FILL, LOAD or UNPK is ignored.
- rden is never asserted outside FILL and never on consecutive cycles. The block never reads an empty FIFO.
- Throughput: 1 move/cycle within a word. Word-to-word overhead is 2 cycles (FILL, LOAD).
- Latency: start to first mv_valid is 3 cycles when the FIFO is non-empty.
- done rises 1 cycle after FILL sees fifoEmpty=1 with src_done=1.

Test Plan:
- Reset: hold reset=0 for 2 cycles during UNPK with mv_valid=1, release -> rden=0, mv_valid=0, done=0, mv_count=0; state IDLE; a start pulse is then required before any rden.
- Sparse word: FIFO holds one word, slot7 = {7'b0000001, 6'o12, 6'o23}, slot2 = {7'b0010000, 6'o11, 6'o12}, all other slots invalid; start with mv_ready=1, then src_done=1 -> exactly two moves, slot7 then slot2, on consecutive cycles; mv_count=2; done=1.
- Backpressure: same word with mv_ready=0 for 5 cycles, then 1 -> mv_data stable at slot7 for all 5 cycles; no extra rden; order preserved; mv_count=2.
- Multi-word: 3 words, each with 8 valid slots; mv_ready=1 -> 24 moves in order; rden pulsed exactly 3 times; each FIFO read preceded by fifoEmpty=0; mv_count=24.
- Late producer: start with empty FIFO and src_done=0 for 10 cycles, then write 1 word, then src_done=1 -> block stays in FILL without rden; emits the word's moves; done rises only after the FIFO is empty.
- All-invalid word followed by a valid word: zero moves from the first word; the second word's moves emitted; done=1; restart with start -> done=0 and mv_count=0 the next cycle.
